// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave to simple word-register port bridge.
// Independent write and read FSMs, one outstanding transaction each.
module axil_reg_bridge #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS       = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                        s_axil_awvalid,
    output logic                        s_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                        s_axil_wvalid,
    output logic                        s_axil_wready,
    output logic [1:0]                  s_axil_bresp,
    output logic                        s_axil_bvalid,
    input  logic                        s_axil_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                        s_axil_arvalid,
    output logic                        s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                  s_axil_rresp,
    output logic                        s_axil_rvalid,
    input  logic                        s_axil_rready,
    output logic                        reg_wr_en,
    output logic [AXI_ADDR_WIDTH-1:0]   reg_wr_addr,
    output logic [AXI_DATA_WIDTH-1:0]   reg_wr_data,
    output logic                        reg_rd_en,
    output logic [AXI_ADDR_WIDTH-1:0]   reg_rd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   reg_rd_data
);

    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam logic [AXI_ADDR_WIDTH-1:0] LIMIT = AXI_ADDR_WIDTH'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_COLLECT, W_STROBE, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_CAPTURE, R_RESP} rstate_t;

    // ---------------- write path ----------------
    wstate_t                   r_wstate, w_wstate_nxt;
    logic                      r_aw_full, r_w_full;
    logic [AXI_ADDR_WIDTH-1:0] r_aw_idx;
    logic [AXI_DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]         r_wstrb;
    logic                      r_awready, r_wready, r_bvalid, r_wr_en;
    logic [1:0]                r_bresp;
    logic [AXI_ADDR_WIDTH-1:0] r_wr_addr;
    logic [AXI_DATA_WIDTH-1:0] r_wr_data;

    logic                      w_aw_hs, w_w_hs, w_b_hs, w_wr_ok;
    logic                      w_aw_full_nxt, w_w_full_nxt;
    logic [AXI_ADDR_WIDTH-1:0] w_aw_idx_in, w_aw_idx_cur;
    logic [AXI_DATA_WIDTH-1:0] w_wdata_cur;
    logic [STRB_W-1:0]         w_wstrb_cur;
    logic                      w_awready_nxt, w_wready_nxt, w_bvalid_nxt, w_wr_en_nxt;
    logic [1:0]                w_bresp_nxt;
    logic [AXI_ADDR_WIDTH-1:0] w_wr_addr_nxt;
    logic [AXI_DATA_WIDTH-1:0] w_wr_data_nxt;

    // Handshakes and the "buffer or live channel" view used on the collect edge
    assign w_aw_hs       = s_axil_awvalid & r_awready;
    assign w_w_hs        = s_axil_wvalid & r_wready;
    assign w_b_hs        = r_bvalid & s_axil_bready;
    assign w_aw_idx_in   = s_axil_awaddr >> 2;
    assign w_aw_idx_cur  = r_aw_full ? r_aw_idx : w_aw_idx_in;
    assign w_wdata_cur   = r_w_full ? r_wdata : s_axil_wdata;
    assign w_wstrb_cur   = r_w_full ? r_wstrb : s_axil_wstrb;
    assign w_wr_ok       = (w_aw_idx_cur < LIMIT) && (&w_wstrb_cur);
    assign w_aw_full_nxt = w_b_hs ? 1'b0 : (r_aw_full | w_aw_hs);
    assign w_w_full_nxt  = w_b_hs ? 1'b0 : (r_w_full | w_w_hs);

    // Write FSM state and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wstate  <= W_COLLECT;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

    // Write FSM next state: strobe as soon as both channels are (or become) held
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_COLLECT: if ((r_aw_full | w_aw_hs) && (r_w_full | w_w_hs)) w_wstate_nxt = W_STROBE;
            W_STROBE:  w_wstate_nxt = W_RESP;
            W_RESP:    if (s_axil_bready) w_wstate_nxt = W_COLLECT;
            default:   w_wstate_nxt = W_COLLECT;
        endcase
    end

    // Write output decode, evaluated one edge ahead so outputs are registered
    always_comb begin
        w_awready_nxt = (w_wstate_nxt == W_COLLECT) && !w_aw_full_nxt;
        w_wready_nxt  = (w_wstate_nxt == W_COLLECT) && !w_w_full_nxt;
        w_bvalid_nxt  = (w_wstate_nxt == W_RESP);
        w_wr_en_nxt   = 1'b0;
        w_bresp_nxt   = r_bresp;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        if ((r_wstate == W_COLLECT) && (w_wstate_nxt == W_STROBE)) begin
            w_wr_en_nxt = w_wr_ok;
            w_bresp_nxt = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (w_wr_ok) begin
                w_wr_addr_nxt = w_aw_idx_cur;
                w_wr_data_nxt = w_wdata_cur;
            end
        end
    end

    // AW/W holding buffers, emptied by the B handshake
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_aw_full <= w_aw_full_nxt;
            r_w_full  <= w_w_full_nxt;
            if (w_aw_hs) r_aw_idx <= w_aw_idx_in;
            if (w_w_hs) begin
                r_wdata <= s_axil_wdata;
                r_wstrb <= s_axil_wstrb;
            end
        end
    end

    // ---------------- read path ----------------
    rstate_t                   r_rstate, w_rstate_nxt;
    logic                      r_ar_oor;
    logic                      r_arready, r_rvalid, r_rd_en;
    logic [1:0]                r_rresp;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [AXI_ADDR_WIDTH-1:0] r_rd_addr;

    logic                      w_ar_hs, w_ar_oor_in;
    logic [AXI_ADDR_WIDTH-1:0] w_ar_idx_in;
    logic                      w_arready_nxt, w_rvalid_nxt, w_rd_en_nxt;
    logic [1:0]                w_rresp_nxt;
    logic [AXI_DATA_WIDTH-1:0] w_rdata_nxt;
    logic [AXI_ADDR_WIDTH-1:0] w_rd_addr_nxt;

    assign w_ar_hs     = s_axil_arvalid & r_arready;
    assign w_ar_idx_in = s_axil_araddr >> 2;
    assign w_ar_oor_in = (w_ar_idx_in >= LIMIT);

    // Read FSM state, OOR flag and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rstate  <= R_IDLE;
            r_ar_oor  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            if (w_ar_hs) r_ar_oor <= w_ar_oor_in;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rresp   <= w_rresp_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_rd_addr <= w_rd_addr_nxt;
        end
    end

    // Read FSM next state: fixed issue/capture pipeline, then wait for rready
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:    if (w_ar_hs) w_rstate_nxt = R_ISSUE;
            R_ISSUE:   w_rstate_nxt = R_CAPTURE;
            R_CAPTURE: w_rstate_nxt = R_RESP;
            R_RESP:    if (s_axil_rready) w_rstate_nxt = R_IDLE;
            default:   w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read output decode; reg_rd_data is sampled while in R_CAPTURE
    always_comb begin
        w_arready_nxt = (w_rstate_nxt == R_IDLE);
        w_rvalid_nxt  = (w_rstate_nxt == R_RESP);
        w_rd_en_nxt   = (r_rstate == R_IDLE) && w_ar_hs && !w_ar_oor_in;
        w_rd_addr_nxt = w_rd_en_nxt ? w_ar_idx_in : r_rd_addr;
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;
        if (r_rstate == R_CAPTURE) begin
            w_rdata_nxt = r_ar_oor ? '0 : reg_rd_data;
            w_rresp_nxt = r_ar_oor ? RESP_SLVERR : RESP_OKAY;
        end
    end

    assign s_axil_awready = r_awready;
    assign s_axil_wready  = r_wready;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;
    assign s_axil_arready = r_arready;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rresp   = r_rresp;
    assign s_axil_rdata   = r_rdata;
    assign reg_wr_en      = r_wr_en;
    assign reg_wr_addr    = r_wr_addr;
    assign reg_wr_data    = r_wr_data;
    assign reg_rd_en      = r_rd_en;
    assign reg_rd_addr    = r_rd_addr;

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Directed self-checking bench for axil_reg_bridge with a 16-word register model.
module tb_axil_reg_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] s_axil_awaddr, s_axil_wdata, s_axil_araddr, s_axil_rdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
    logic [1:0]  s_axil_bresp, s_axil_rresp;
    logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
    logic        s_axil_rvalid, s_axil_rready;
    logic        reg_wr_en, reg_rd_en;
    logic [31:0] reg_wr_addr, reg_wr_data, reg_rd_addr, reg_rd_data;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    logic [31:0] mem [16];

    always #5 clk = ~clk;

    axil_reg_bridge #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .NUM_REGS(16)) dut (
        .clk(clk), .rstn(rstn),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
        .s_axil_rready(s_axil_rready),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data)
    );

    // Register file model: preloaded in reset, one-cycle read latency
    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++)
                mem[i] <= (i == 15) ? 32'hABCD_0123 : (32'hC0DE_0000 | 32'(i));
            reg_rd_data <= 32'h0;
        end else begin
            if (reg_wr_en) begin
                wr_cnt++;
                mem[reg_wr_addr[3:0]] <= reg_wr_data;
            end
            if (reg_rd_en) begin
                rd_cnt++;
                reg_rd_data <= mem[reg_rd_addr[3:0]];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_axil_awaddr = '0; s_axil_awvalid = 1'b0;
        s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
        s_axil_bready = 1'b0;
        s_axil_araddr = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        repeat (3) step();
        n_checks++;
        if ({s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp, s_axil_arready, s_axil_rvalid,
             s_axil_rresp, s_axil_rdata, reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_en, reg_rd_addr} !== '0) begin
            n_fail++; $display("FAIL reset_outputs_zero: some output nonzero during reset");
        end
        rstn = 1'b1;
        step();
        n_checks++;
        if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b111) begin
            n_fail++; $display("FAIL reset_release_ready got=%b exp=111",
                               {s_axil_awready, s_axil_wready, s_axil_arready});
        end
    endtask

    task automatic test_write_same_cycle();
        s_axil_awaddr = 32'h08; s_axil_awvalid = 1'b1;
        s_axil_wdata = 32'h1000_0000; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
        s_axil_bready = 1'b1;
        step();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        n_checks++;
        if ({reg_wr_en, reg_wr_addr, reg_wr_data} !== {1'b1, 32'd2, 32'h1000_0000}) begin
            n_fail++; $display("FAIL wr_same_strobe got en=%b addr=%0d data=%h exp en=1 addr=2 data=10000000",
                               reg_wr_en, reg_wr_addr, reg_wr_data);
        end
        step();
        n_checks++;
        if ({s_axil_bvalid, s_axil_bresp, reg_wr_en} !== 4'b1000) begin
            n_fail++; $display("FAIL wr_same_bresp got bvalid=%b bresp=%b wr_en=%b exp 1 00 0",
                               s_axil_bvalid, s_axil_bresp, reg_wr_en);
        end
        step();
        n_checks++;
        if ({s_axil_bvalid, s_axil_awready, s_axil_wready} !== 3'b011) begin
            n_fail++; $display("FAIL wr_same_done got bvalid/awready/wready=%b exp 011",
                               {s_axil_bvalid, s_axil_awready, s_axil_wready});
        end
    endtask

    task automatic test_w_before_aw();
        int cnt0;
        cnt0 = wr_cnt;
        s_axil_bready = 1'b0;
        s_axil_wdata = 32'h5555_AAAA; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
        step();
        s_axil_wvalid = 1'b0;
        n_checks++;
        if ({s_axil_wready, s_axil_awready, reg_wr_en} !== 3'b010) begin
            n_fail++; $display("FAIL wfirst_hold got wready/awready/wr_en=%b exp 010",
                               {s_axil_wready, s_axil_awready, reg_wr_en});
        end
        step();
        step();
        s_axil_awaddr = 32'h0C; s_axil_awvalid = 1'b1;
        step();
        s_axil_awvalid = 1'b0;
        n_checks++;
        if ({reg_wr_en, reg_wr_addr, reg_wr_data, s_axil_awready, s_axil_wready} !==
            {1'b1, 32'd3, 32'h5555_AAAA, 2'b00}) begin
            n_fail++; $display("FAIL wfirst_strobe got en=%b addr=%0d data=%h rdy=%b%b exp 1 3 5555aaaa 00",
                               reg_wr_en, reg_wr_addr, reg_wr_data, s_axil_awready, s_axil_wready);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({s_axil_bvalid, s_axil_bresp, s_axil_awready, s_axil_wready, reg_wr_en} !== 6'b100000) begin
                n_fail++; $display("FAIL wfirst_bhold cyc=%0d got bvalid=%b bresp=%b rdy=%b%b en=%b exp 1 00 00 0",
                                   i, s_axil_bvalid, s_axil_bresp, s_axil_awready, s_axil_wready, reg_wr_en);
            end
        end
        s_axil_bready = 1'b1;
        step();
        n_checks++;
        if (s_axil_bvalid !== 1'b0 || (wr_cnt - cnt0) !== 1) begin
            n_fail++; $display("FAIL wfirst_done got bvalid=%b pulses=%0d exp 0 1", s_axil_bvalid, wr_cnt - cnt0);
        end
    endtask

    task automatic test_read();
        s_axil_rready = 1'b0;
        s_axil_araddr = 32'h3C; s_axil_arvalid = 1'b1;
        step();
        s_axil_arvalid = 1'b0;
        n_checks++;
        if ({reg_rd_en, reg_rd_addr, s_axil_arready} !== {1'b1, 32'd15, 1'b0}) begin
            n_fail++; $display("FAIL rd_issue got en=%b addr=%0d arready=%b exp 1 15 0",
                               reg_rd_en, reg_rd_addr, s_axil_arready);
        end
        step();
        n_checks++;
        if ({reg_rd_en, s_axil_rvalid} !== 2'b00) begin
            n_fail++; $display("FAIL rd_capture got en=%b rvalid=%b exp 0 0", reg_rd_en, s_axil_rvalid);
        end
        repeat (2) begin
            step();
            n_checks++;
            if ({s_axil_rvalid, s_axil_rresp, s_axil_rdata} !== {1'b1, 2'b00, 32'hABCD_0123}) begin
                n_fail++; $display("FAIL rd_resp got rvalid=%b rresp=%b rdata=%h exp 1 00 abcd0123",
                                   s_axil_rvalid, s_axil_rresp, s_axil_rdata);
            end
        end
        s_axil_rready = 1'b1;
        step();
        n_checks++;
        if ({s_axil_rvalid, s_axil_arready} !== 2'b01) begin
            n_fail++; $display("FAIL rd_done got rvalid=%b arready=%b exp 0 1", s_axil_rvalid, s_axil_arready);
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [2];
        logic [3:0]  strbs [2];
        int wc0, rc0;
        addrs[0] = 32'h40; strbs[0] = 4'hF;
        addrs[1] = 32'h04; strbs[1] = 4'h3;
        wc0 = wr_cnt; rc0 = rd_cnt;
        s_axil_bready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s_axil_awaddr = addrs[k]; s_axil_awvalid = 1'b1;
            s_axil_wdata = 32'hDEAD_BEEF; s_axil_wstrb = strbs[k]; s_axil_wvalid = 1'b1;
            step();
            s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
            n_checks++;
            if ({reg_wr_en, reg_wr_addr, reg_wr_data} !== {1'b0, 32'd3, 32'h5555_AAAA}) begin
                n_fail++; $display("FAIL err_wr%0d_suppress got en=%b addr=%0d data=%h exp 0 3 5555aaaa",
                                   k, reg_wr_en, reg_wr_addr, reg_wr_data);
            end
            step();
            n_checks++;
            if ({s_axil_bvalid, s_axil_bresp} !== 3'b110) begin
                n_fail++; $display("FAIL err_wr%0d_bresp got bvalid=%b bresp=%b exp 1 10",
                                   k, s_axil_bvalid, s_axil_bresp);
            end
            step();
        end
        s_axil_rready = 1'b1;
        s_axil_araddr = 32'h44; s_axil_arvalid = 1'b1;
        step();
        s_axil_arvalid = 1'b0;
        step();
        step();
        n_checks++;
        if ({s_axil_rvalid, s_axil_rresp, s_axil_rdata} !== {1'b1, 2'b10, 32'h0}) begin
            n_fail++; $display("FAIL err_rd_resp got rvalid=%b rresp=%b rdata=%h exp 1 10 0",
                               s_axil_rvalid, s_axil_rresp, s_axil_rdata);
        end
        step();
        n_checks++;
        if ((wr_cnt - wc0) !== 0 || (rd_cnt - rc0) !== 0 || reg_rd_addr !== 32'd15) begin
            n_fail++; $display("FAIL err_no_strobe got wr=%0d rd=%0d rd_addr=%0d exp 0 0 15",
                               wr_cnt - wc0, rd_cnt - rc0, reg_rd_addr);
        end
    endtask

    task automatic test_concurrent();
        s_axil_bready = 1'b1; s_axil_rready = 1'b1;
        s_axil_awaddr = 32'h10; s_axil_awvalid = 1'b1;
        s_axil_wdata = 32'h1234_5678; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
        s_axil_araddr = 32'h14; s_axil_arvalid = 1'b1;
        step();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
        n_checks++;
        if ({reg_wr_en, reg_wr_addr, reg_rd_en, reg_rd_addr} !== {1'b1, 32'd4, 1'b1, 32'd5}) begin
            n_fail++; $display("FAIL conc_strobes got wr=%b/%0d rd=%b/%0d exp 1/4 1/5",
                               reg_wr_en, reg_wr_addr, reg_rd_en, reg_rd_addr);
        end
        step();
        n_checks++;
        if ({s_axil_bvalid, s_axil_bresp, s_axil_rvalid} !== 4'b1000) begin
            n_fail++; $display("FAIL conc_b got bvalid=%b bresp=%b rvalid=%b exp 1 00 0",
                               s_axil_bvalid, s_axil_bresp, s_axil_rvalid);
        end
        step();
        n_checks++;
        if ({s_axil_rvalid, s_axil_rresp, s_axil_rdata, s_axil_bvalid} !== {1'b1, 2'b00, 32'hC0DE_0005, 1'b0}) begin
            n_fail++; $display("FAIL conc_r got rvalid=%b rresp=%b rdata=%h bvalid=%b exp 1 00 c0de0005 0",
                               s_axil_rvalid, s_axil_rresp, s_axil_rdata, s_axil_bvalid);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr [4];
        logic [31:0] exp  [4];
        addr[0] = 32'h0C; exp[0] = 32'h5555_AAAA;
        addr[1] = 32'h10; exp[1] = 32'h1234_5678;
        addr[2] = 32'h0B; exp[2] = 32'h1000_0000;
        addr[3] = 32'h04; exp[3] = 32'hC0DE_0001;
        s_axil_rready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_axil_araddr = addr[k]; s_axil_arvalid = 1'b1;
            step();
            s_axil_arvalid = 1'b0;
            step();
            step();
            n_checks++;
            if ({s_axil_rvalid, s_axil_rresp, s_axil_rdata} !== {1'b1, 2'b00, exp[k]}) begin
                n_fail++; $display("FAIL b2b_rd%0d got rvalid=%b rresp=%b rdata=%h exp 1 00 %h",
                                   k, s_axil_rvalid, s_axil_rresp, s_axil_rdata, exp[k]);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_read();
        s_axil_rready = 1'b0;
        s_axil_araddr = 32'h00; s_axil_arvalid = 1'b1;
        step();
        s_axil_arvalid = 1'b0;
        step();
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({s_axil_rvalid, s_axil_arready, reg_rd_en} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_async got rvalid/arready/rd_en=%b exp 000",
                               {s_axil_rvalid, s_axil_arready, reg_rd_en});
        end
        step();
        rstn = 1'b1;
        s_axil_rready = 1'b1;
        step();
        n_checks++;
        if ({s_axil_arready, s_axil_rvalid} !== 2'b10) begin
            n_fail++; $display("FAIL rstmid_release got arready=%b rvalid=%b exp 1 0",
                               s_axil_arready, s_axil_rvalid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({s_axil_rvalid, s_axil_bvalid, reg_rd_en, reg_wr_en} !== 4'b0000) begin
                n_fail++; $display("FAIL rstmid_stale cyc=%0d got rvalid/bvalid/rd_en/wr_en=%b exp 0000",
                                   i, {s_axil_rvalid, s_axil_bvalid, reg_rd_en, reg_wr_en});
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_read();
        test_errors();
        test_concurrent();
        test_back_to_back();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_reg_bridge.md
AXIL_REG_BRIDGE -- requirements
Module: axil_reg_bridge

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, AXI-Lite and register-port address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, data width; the byte count is AXI_DATA_WIDTH/8.
REQ-003 SHALL have parameter NUM_REGS, default 16, number of valid word registers behind the port.
REQ-004 SHALL have ports: clk in 1 clock; rstn in 1 reset (one clock domain, asynchronous active-low reset).
REQ-005 SHALL have AW ports: s_axil_awaddr in AXI_ADDR_WIDTH; s_axil_awvalid in 1; s_axil_awready out 1.
REQ-006 SHALL have W ports: s_axil_wdata in AXI_DATA_WIDTH; s_axil_wstrb in AXI_DATA_WIDTH/8; s_axil_wvalid in 1; s_axil_wready out 1.
REQ-007 SHALL have B ports: s_axil_bresp out 2; s_axil_bvalid out 1; s_axil_bready in 1.
REQ-008 SHALL have AR ports: s_axil_araddr in AXI_ADDR_WIDTH; s_axil_arvalid in 1; s_axil_arready out 1.
REQ-009 SHALL have R ports: s_axil_rdata out AXI_DATA_WIDTH; s_axil_rresp out 2; s_axil_rvalid out 1; s_axil_rready in 1.
REQ-010 SHALL have register-port outputs: reg_wr_en out 1; reg_wr_addr out AXI_ADDR_WIDTH (word index); reg_wr_data out AXI_DATA_WIDTH; reg_rd_en out 1; reg_rd_addr out AXI_ADDR_WIDTH (word index).
REQ-011 SHALL have register-port input reg_rd_data in AXI_DATA_WIDTH, valid exactly 1 clk after reg_rd_en.

Function
REQ-012 SHALL form the word index as addr >> 2, ignore addr[1:0], and treat an index >= NUM_REGS as out-of-range (OOR).
REQ-013 SHALL run independent write and read FSMs, each with one outstanding transaction; a read and a write SHALL be able to proceed in the same cycle.
REQ-014 Write FSM SHALL have states W_COLLECT, W_STROBE and W_RESP.
REQ-015 In W_COLLECT, awready SHALL be 1 while the AW buffer is empty and wready SHALL be 1 while the W buffer is empty; each handshake latches its channel, in either order or in the same cycle.
REQ-016 When both buffers are full, the write FSM SHALL enter W_STROBE on the next edge.
REQ-017 In W_STROBE, reg_wr_en SHALL be 1 for exactly 1 cycle, with reg_wr_addr and reg_wr_data taken from the buffers, if the address is in range and wstrb is all ones.
REQ-018 If the write is OOR or wstrb is not all ones, the write SHALL be suppressed (reg_wr_en stays 0) and bresp SHALL be 2'b10 SLVERR; otherwise bresp SHALL be 2'b00.
REQ-019 From W_STROBE the write FSM SHALL go to W_RESP, where bvalid=1 and bresp are held stable until bready; on the B handshake it SHALL clear both buffers and return to W_COLLECT.
REQ-020 awready and wready SHALL be 0 in W_STROBE and W_RESP.
REQ-021 Read FSM SHALL have states R_IDLE, R_ISSUE, R_CAPTURE and R_RESP.
REQ-022 In R_IDLE, arready SHALL be 1; on the AR handshake it SHALL latch the index and go to R_ISSUE.
REQ-023 In R_ISSUE, reg_rd_en SHALL be 1 for 1 cycle with reg_rd_addr equal to the index, if in range; the read FSM SHALL then go to R_CAPTURE.
REQ-024 In R_CAPTURE, rdata SHALL be registered from reg_rd_data with rresp 2'b00; for an OOR read, rdata SHALL be 0, rresp 2'b10, and reg_rd_en SHALL never be asserted.
REQ-025 In R_RESP, rvalid SHALL be 1 and rdata/rresp stable until rready; on the R handshake the read FSM SHALL return to R_IDLE.
REQ-026 Latency SHALL be: reg_wr_en 1 cycle after the later of AW/W; bvalid 2 cycles after; reg_rd_en 1 cycle after AR; rvalid 3 cycles after AR.
REQ-027 arready SHALL be 0 outside R_IDLE.
REQ-028 reg_wr_addr, reg_wr_data and reg_rd_addr SHALL hold their last values when their strobes are 0.

Reset
REQ-029 On rstn=0, the block SHALL reset asynchronously, at any time including mid-transaction.
REQ-030 On reset, all outputs SHALL be 0, both FSMs SHALL go to W_COLLECT/R_IDLE, buffers SHALL empty, and in-flight transactions SHALL be dropped with no strobe and no response.
REQ-031 On reset release, ready outputs SHALL assert on the first clk edge with rstn=1.

Verification
REQ-032 AW 0x08 and W 0x1000_0000/wstrb 0xF in the same cycle -> next cycle reg_wr_en=1, addr 2, data 0x1000_0000; the cycle after that, bvalid=1 with bresp 00.
REQ-033 W given 3 cycles before AW 0x0C; bready held low for 5 cycles -> a single reg_wr_en pulse to addr 3; bvalid held 5 cycles; awready/wready 0 throughout.
REQ-034 Read 0x3C with the model returning 0xABCD_0123 -> reg_rd_en with addr 15 one cycle after AR; rvalid with rdata 0xABCD_0123 and rresp 00 three cycles after AR.
REQ-035 Write to 0x40, write with wstrb 0x3, and read from 0x44 -> no reg_wr_en and no reg_rd_en; bresp 10 for both writes; rresp 10 with rdata 0.
REQ-036 A write and a read issued in the same cycle -> both complete with the latencies of REQ-026.
REQ-037 rstn pulsed low in R_CAPTURE -> rvalid is 0 immediately, arready is 1 after release, and no stale response appears.
